programmable_pulse_generator: RTL and testbench

Parametrised periodic pulse source with runtime-programmable period, pulse width and burst length. Supports continuous and burst modes, start/stop control, and busy/done status. Intended for timing strobes, enable ticks and test stimulus in lab designs, in place of fixed divide-by-N tick generators. Configuration is latched at start, so software or upstream logic may change inputs freely while a run is active.

---
 rtl/ppg_pkg.sv | 13 +
 rtl/ppg_phase_counter.sv | 43 ++++
 rtl/programmable_pulse_generator.sv | 127 ++++++++++++
 tb/tb_programmable_pulse_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// Shared types and constants for the programmable pulse generator.
package ppg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/ppg_phase_counter.sv
// Phase counter within one period: counts 0..term, wraps to 0, term latched on load.
module ppg_phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] phase,
    output logic [CNT_W-1:0] phase_next,
    output logic             wrap
);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] term_q, term_d;

    assign wrap       = (phase_q == term_q);
    assign phase_next = wrap ? '0 : phase_q + CNT_W'(1);
    assign phase      = phase_q;

    always_comb begin
        phase_d = phase_q;
        term_d  = term_q;
        if (load) begin
            phase_d = '0;
            term_d  = term;
        end else if (enable) begin
            phase_d = phase_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            term_q  <= '0;
        end else begin
            phase_q <= phase_d;
            term_q  <= term_d;
        end
    end

endmodule

// File: rtl/programmable_pulse_generator.sv
// Periodic pulse source with latched period/width/burst config, continuous or burst mode.
module programmable_pulse_generator
    import ppg_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   width,
    input  logic [BURST_W-1:0] burst_len,
    output logic               pulse,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [BURST_W-1:0] blast_q, blast_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;

    logic               cnt_load, cnt_en, wrap;
    logic [CNT_W-1:0]   term, phase, phase_next;

    // A zero period behaves as one cycle, so the terminal phase is max(P,1)-1.
    assign term = (period == '0) ? '0 : period - CNT_W'(1);

    ppg_phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .enable     (cnt_en),
        .term       (term),
        .phase      (phase),
        .phase_next (phase_next),
        .wrap       (wrap)
    );

    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mode_d   = mode_q;
        width_d  = width_q;
        blast_d  = blast_q;
        pcnt_d   = pcnt_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    width_d  = width;
                    blast_d  = (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
                    pcnt_d   = '0;
                    cnt_load = 1'b1;
                    pulse_d  = (width != '0);
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                // Stop outranks the burst-end transition taken on the same edge.
                if (stop || (mode_q == MODE_BURST && wrap && pcnt_q == blast_q)) begin
                    state_d = FINISH;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pulse_d = (phase_next < width_q);
                    if (wrap) begin
                        pcnt_d = pcnt_q + BURST_W'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            width_q <= '0;
            blast_q <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            width_q <= width_d;
            blast_q <= blast_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_programmable_pulse_generator.sv
// Self-checking bench: table-driven bursts plus hand sequences, with an expectation queue.
module tb_programmable_pulse_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, mode;
    logic [15:0] period, width;
    logic [7:0]  burst_len;
    logic        pulse, busy, done;

    programmable_pulse_generator #(
        .CNT_W   (16),
        .BURST_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .width     (width),
        .burst_len (burst_len),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;     // {pulse, busy, done}
        string      tag;
        int         cyc;
    } exp_t;

    typedef struct {
        logic        mode;
        logic [15:0] period;
        logic [15:0] width;
        logic [7:0]  burst_len;
        int          exp_len;
        int          exp_high;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   dut_highs = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if ({pulse, busy, done} !== e.v) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got pulse/busy/done=%b required %b",
                         e.tag, e.cyc, {pulse, busy, done}, e.v);
            end
            if (pulse === 1'b1) dut_highs++;
        end
    end

    task automatic expect_edge(input logic p, input logic b, input logic d,
                               input string tag, input int cyc);
        exp_t e;
        @(posedge clk);
        e.v = {p, b, d};
        e.tag = tag;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string tag, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", tag, got, req);
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    // Burst run with config scrambling and ignored starts once the run is under way.
    task automatic run_vec(input vec_t v, input string tag);
        int p, n, highs;
        p = (v.period == 16'd0) ? 1 : int'(v.period);
        n = (v.burst_len == 8'd0) ? 1 : int'(v.burst_len);
        highs = 0;
        drain();
        dut_highs = 0;
        mode = v.mode; period = v.period; width = v.width; burst_len = v.burst_len;
        start = 1'b1; stop = 1'b0;
        for (int t = 0; t < p * n; t++) begin
            logic ph;
            ph = ((t % p) < int'(v.width));
            if (ph) highs++;
            expect_edge(ph, 1'b1, 1'b0, tag, t);
            #1;
            start     = 1'($urandom_range(0, 1));
            period    = 16'($urandom_range(0, 9));
            width     = 16'($urandom_range(0, 9));
            burst_len = 8'($urandom_range(0, 5));
            mode      = ~v.mode;
        end
        expect_edge(1'b0, 1'b0, 1'b1, tag, p * n);
        #1 start = 1'b1;
        expect_edge(1'b0, 1'b0, 1'b0, tag, p * n + 1);
        #1 start = 1'b0;
        expect_edge(1'b0, 1'b0, 1'b0, tag, p * n + 2);
        drain();
        check_val({tag, "_len"}, p * n, v.exp_len);
        check_val({tag, "_highs"}, dut_highs, v.exp_high);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 16'd4, 16'd2, 8'd3, 12, 6};
        vecs[1] = '{1'b1, 16'd5, 16'd1, 8'd2, 10, 2};
        vecs[2] = '{1'b1, 16'd4, 16'd0, 8'd2,  8, 0};
        vecs[3] = '{1'b1, 16'd4, 16'd7, 8'd2,  8, 8};
        vecs[4] = '{1'b1, 16'd0, 16'd1, 8'd3,  3, 3};
        vecs[5] = '{1'b1, 16'd3, 16'd1, 8'd0,  3, 1};
        vecs[6] = '{1'b1, 16'd1, 16'd0, 8'd1,  1, 0};

        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = '0; width = '0; burst_len = '0;
        #3;
        check_val("reset_outputs", int'({pulse, busy, done}), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Continuous P=5 W=1: high every fifth cycle until stopped.
        mode = 1'b0; period = 16'd5; width = 16'd1; burst_len = 8'd1; start = 1'b1;
        for (int t = 0; t < 22; t++) begin
            expect_edge((t % 5) == 0, 1'b1, 1'b0, "cont", t);
            #1 start = 1'b0; burst_len = 8'd2; mode = 1'b1;
        end
        stop = 1'b1;
        expect_edge(1'b0, 1'b0, 1'b1, "cont_stop", 22);
        #1 stop = 1'b0;
        for (int t = 23; t < 26; t++) expect_edge(1'b0, 1'b0, 1'b0, "cont_idle", t);
        drain();

        // Stop during cycle 6 of a P=4 N=3 burst; no second done later.
        mode = 1'b1; period = 16'd4; width = 16'd2; burst_len = 8'd3; start = 1'b1;
        for (int t = 0; t < 7; t++) begin
            expect_edge((t % 4) < 2, 1'b1, 1'b0, "bstop", t);
            #1 start = 1'b0;
        end
        stop = 1'b1;
        expect_edge(1'b0, 1'b0, 1'b1, "bstop_done", 7);
        #1 stop = 1'b0;
        for (int t = 8; t < 16; t++) expect_edge(1'b0, 1'b0, 1'b0, "bstop_idle", t);
        drain();

        // start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        for (int t = 0; t < 4; t++) expect_edge(1'b0, 1'b0, 1'b0, "start_stop", t);
        #1 start = 1'b0; stop = 1'b0;
        // stop alone in IDLE: no done.
        stop = 1'b1;
        for (int t = 0; t < 3; t++) expect_edge(1'b0, 1'b0, 1'b0, "stop_idle", t);
        #1 stop = 1'b0;
        drain();

        // Async reset mid-burst clears outputs at once, then a fresh burst runs normally.
        mode = 1'b1; period = 16'd4; width = 16'd7; burst_len = 8'd3; start = 1'b1;
        for (int t = 0; t < 5; t++) begin
            expect_edge(1'b1, 1'b1, 1'b0, "pre_reset", t);
            #1 start = 1'b0;
        end
        drain();
        #2 reset = 1'b1;
        #1 check_val("async_reset", int'({pulse, busy, done}), 0);
        @(negedge clk);
        check_val("reset_held", int'({pulse, busy, done}), 0);
        reset = 1'b0;
        for (int t = 0; t < 3; t++) expect_edge(1'b0, 1'b0, 1'b0, "post_reset_idle", t);
        drain();
        run_vec(vecs[0], "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule
